// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM encoding, counter width default and stage-control bundle for the pipeline.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2, REPLAY = 2'd3} state_t;
  localparam int CntWDefault = 32;
  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExBubble;
    logic exMemWrite;
    logic memWbBubble;
  } stageCtrl_t;
  localparam stageCtrl_t CtrlIdle   = 6'b000110;
  localparam stageCtrl_t CtrlFreeze = 6'b000001;
  localparam stageCtrl_t CtrlHazard = 6'b000110;
  localparam stageCtrl_t CtrlBranch = 6'b111010;
  localparam stageCtrl_t CtrlGo     = 6'b110010;
endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk_i)
    if (rst_i || clr_i) cnt_o <= '0;
    else if (inc_i && !(&cnt_o)) cnt_o <= cnt_o + 1'b1;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges load-use, branch and dcache-miss events into per-stage pipeline controls.
module pipe_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W   = CntWDefault,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_i,
  input  logic             branch_taken_i,
  input  logic             mem_access_i,
  input  logic             dcache_hit_i,
  input  logic             dcache_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_bubble_o,
  output logic             dcache_req_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
  state_t state;
  stageCtrl_t ctrl;
  logic [TW-1:0] waitCnt;
  logic miss, inWait;
  assign miss   = (state == RUN) && mem_access_i && !dcache_hit_i;
  assign inWait = (state == MEM_WAIT);
  always_comb
    ctrl = (state == IDLE) ? CtrlIdle :
           (miss || inWait) ? CtrlFreeze :
           hazard_i ? CtrlHazard :
           branch_taken_i ? CtrlBranch : CtrlGo;
  assign {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, ex_mem_write_o, mem_wb_bubble_o} = ctrl;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state        <= IDLE;
      dcache_req_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= start_i ? RUN : IDLE;
        RUN:
          if (miss) begin
            state        <= MEM_WAIT;
            dcache_req_o <= 1'b1;
          end
        MEM_WAIT:
          if (dcache_ack_i) begin
            state        <= REPLAY;
            dcache_req_o <= 1'b0;
          end else if (waitCnt >= TimeoutLast) err_o <= 1'b1;
        REPLAY: state <= RUN;
        default: state <= IDLE;
      endcase
    end
  sat_counter #(.W(TW)) uWaitCnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(inWait && dcache_ack_i),
    .inc_i(inWait && !dcache_ack_i), .cnt_o(waitCnt)
  );
  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(1'b0),
    .inc_i((state != IDLE) && !ctrl.pcWrite), .cnt_o(stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(1'b0),
    .inc_i(ctrl.ifIdFlush), .cnt_o(flush_cnt_o)
  );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed table-driven and sequence checks of the pipeline stall controller.
module tb_pipe_stall_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hazard = 1'b0, branch = 1'b0;
  logic memAcc = 1'b0, hit = 1'b0, ack = 1'b0;
  logic pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemWrite, memWbBubble, req, err;
  logic [31:0] stallCnt, flushCnt;
  int nChecks = 0, nFails = 0;
  int expStall = 0, expFlush = 0;
  always #5 clk = ~clk;
  pipe_stall_ctrl #(.CNT_W(32), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .hazard_i(hazard), .branch_taken_i(branch),
    .mem_access_i(memAcc), .dcache_hit_i(hit), .dcache_ack_i(ack),
    .pc_write_o(pcWrite), .if_id_write_o(ifIdWrite), .if_id_flush_o(ifIdFlush),
    .id_ex_bubble_o(idExBubble), .ex_mem_write_o(exMemWrite), .mem_wb_bubble_o(memWbBubble),
    .dcache_req_o(req), .err_o(err), .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
  );
  localparam logic [5:0] IDLEO = 6'b000110, FRZ = 6'b000001, HAZ = 6'b000110, BR = 6'b111010, GO = 6'b110010;
  typedef struct {
    logic haz, br, mem, hit, ack;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[11];
  function automatic logic [5:0] ctrlNow();
    return {pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemWrite, memWbBubble};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic setIn(input logic h, input logic b, input logic m, input logic ht, input logic a);
    hazard = h; branch = b; memAcc = m; hit = ht; ack = a;
  endtask
  task automatic doStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, GO};
    vecs[1]  = '{1, 0, 0, 0, 0, HAZ};
    vecs[2]  = '{1, 1, 0, 0, 0, HAZ};
    vecs[3]  = '{0, 1, 0, 0, 0, BR};
    vecs[4]  = '{0, 0, 0, 0, 0, GO};
    vecs[5]  = '{0, 1, 0, 0, 0, BR};
    vecs[6]  = '{0, 0, 1, 1, 0, GO};
    vecs[7]  = '{0, 1, 1, 1, 0, BR};
    vecs[8]  = '{1, 0, 1, 1, 0, HAZ};
    vecs[9]  = '{0, 0, 0, 0, 1, GO};
    vecs[10] = '{0, 1, 0, 1, 0, BR};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ctrl", 32'(ctrlNow()), 32'(IDLEO));
    chk("reset_req", 32'(req), 0);
    chk("reset_err", 32'(err), 0);
    for (int i = 0; i < 5; i++) begin
      setIn(1, 1, 1, 0, 1);
      #1 chk("idle_ctrl", 32'(ctrlNow()), 32'(IDLEO));
      tick();
    end
    setIn(0, 0, 0, 0, 0);
    chk("idle_stall_cnt", stallCnt, 0);
    chk("idle_flush_cnt", flushCnt, 0);
    chk("idle_req", 32'(req), 0);
    doStart();
    chk("run_pc_write", 32'(pcWrite), 1);
    for (int i = 0; i < 11; i++) begin
      setIn(vecs[i].haz, vecs[i].br, vecs[i].mem, vecs[i].hit, vecs[i].ack);
      #1 chk($sformatf("vec%0d_ctrl", i), 32'(ctrlNow()), 32'(vecs[i].exp));
      if (!vecs[i].exp[5]) expStall++;
      if (vecs[i].exp[3]) expFlush++;
      tick();
      chk($sformatf("vec%0d_stall", i), stallCnt, expStall);
      chk($sformatf("vec%0d_flush", i), flushCnt, expFlush);
      chk($sformatf("vec%0d_req", i), 32'(req), 0);
    end
    // miss with ack in the 4th refill cycle
    setIn(1, 1, 1, 0, 0);
    #1 chk("miss_ctrl", 32'(ctrlNow()), 32'(FRZ));
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("wait%0d_req", k), 32'(req), 1);
      chk($sformatf("wait%0d_ctrl", k), 32'(ctrlNow()), 32'(FRZ));
      if (k == 4) ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    expStall += 5;
    setIn(0, 0, 1, 0, 0);
    #1 chk("replay_ctrl", 32'(ctrlNow()), 32'(GO));
    chk("replay_req", 32'(req), 0);
    chk("miss_stall_cnt", stallCnt, expStall);
    tick();
    setIn(0, 0, 0, 0, 0);
    #1 chk("after_replay_ctrl", 32'(ctrlNow()), 32'(GO));
    tick();
    chk("after_replay_stall", stallCnt, expStall);
    chk("miss_flush_cnt", flushCnt, expFlush);
    // refill timeout with no ack
    setIn(0, 0, 1, 0, 0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("to%0d_err_before", k), 32'(err), 0);
      tick();
    end
    chk("timeout_err", 32'(err), 1);
    repeat (3) tick();
    chk("timeout_err_sticky", 32'(err), 1);
    chk("timeout_req", 32'(req), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    #1 chk("late_ack_ctrl", 32'(ctrlNow()), 32'(GO));
    chk("late_ack_req", 32'(req), 0);
    chk("late_ack_err", 32'(err), 1);
    tick();
    setIn(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_err", 32'(err), 0);
    chk("rst_stall", stallCnt, 0);
    // reset in the middle of a refill
    doStart();
    setIn(0, 0, 1, 0, 0);
    repeat (3) tick();
    chk("midrefill_req", 32'(req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setIn(0, 0, 0, 0, 0);
    chk("midrst_req", 32'(req), 0);
    chk("midrst_ctrl", 32'(ctrlNow()), 32'(IDLEO));
    chk("midrst_stall", stallCnt, 0);
    chk("midrst_flush", flushCnt, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_ignored_ctrl", 32'(ctrlNow()), 32'(IDLEO));
    chk("ack_ignored_req", 32'(req), 0);
    doStart();
    #1 chk("restart_ctrl", 32'(ctrlNow()), 32'(GO));
    tick();
    chk("restart_stall", stallCnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage CPU.
- Merges three stall/flush sources into one set of per-stage write-enable, bubble and flush controls:
  - load-use hazard indication from the hazard detection unit;
  - taken branch/jump resolved in ID;
  - data-cache miss in MEM.
- Owns the dcache refill request/acknowledge handshake.
- Holds the pipeline idle between reset and start.
- Keeps saturating stall and flush statistics counters.

Parameters:
- CNT_W, 32, width of statistics counters.
- TIMEOUT, 1023, MEM_WAIT cycle count after which err_o is raised.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  leave IDLE; sampled in IDLE only.
- hazard_i  in  1  load-use hazard detected for the instruction in ID.
- branch_taken_i  in  1  taken branch or jump resolved in ID.
- mem_access_i  in  1  instruction in MEM is lw/sw.
- dcache_hit_i  in  1  dcache hit for current MEM access.
- dcache_ack_i  in  1  refill complete; one-cycle pulse.
- pc_write_o  out  1  PC register update enable.
- if_id_write_o  out  1  IF/ID register update enable.
- if_id_flush_o  out  1  load NOP into IF/ID.
- id_ex_bubble_o  out  1  zero ID/EX control fields.
- ex_mem_write_o  out  1  EX/MEM register update enable.
- mem_wb_bubble_o  out  1  zero MEM/WB control fields.
- dcache_req_o  out  1  refill request; registered.
- err_o  out  1  sticky refill-timeout flag.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 outside IDLE.
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o=1.

Behaviour:
- State machine states: IDLE, RUN, MEM_WAIT, REPLAY.
- Reset (rst_i=1 at an edge):
  - state goes to IDLE; dcache_req_o=0; err_o=0; counters=0; timeout counter=0.
  - Takes effect mid-refill as well; dcache_req_o drops at that same edge.
- IDLE:
  - pc_write_o=0, if_id_write_o=0, if_id_flush_o=0, id_ex_bubble_o=1, ex_mem_write_o=1, mem_wb_bubble_o=0.
  - start_i=1 moves to RUN at the next edge.
  - All other inputs are ignored.
- miss = mem_access_i & ~dcache_hit_i. It is evaluated only in RUN.
- RUN with miss (freeze):
  - pc_write_o=0, if_id_write_o=0, ex_mem_write_o=0, mem_wb_bubble_o=1, id_ex_bubble_o=0, if_id_flush_o=0.
  - hazard_i and branch_taken_i are ignored.
  - Next state MEM_WAIT; dcache_req_o=1 from that edge.
- MEM_WAIT:
  - Same freeze outputs; dcache_req_o=1; timeout counter increments.
  - dcache_ack_i=1 moves to REPLAY, clears dcache_req_o and clears the timeout counter.
  - When the timeout counter reaches TIMEOUT, err_o sets (sticky until rst_i). The counter saturates. The state stays in MEM_WAIT.
- REPLAY:
  - Exactly one cycle; no freeze; miss is not evaluated (filled line assumed hit).
  - Hazard/branch rules apply as in RUN.
  - Next state RUN.
- RUN/REPLAY without freeze:
  - hazard_i=1: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, if_id_flush_o=0. branch_taken_i is suppressed because the branch is re-resolved next cycle.
  - Else branch_taken_i=1: pc_write_o=1, if_id_write_o=1, if_id_flush_o=1.
  - Else: all enables 1, all bubbles/flushes 0.
- Priority: IDLE > miss freeze > hazard > branch.
- All stage outputs are combinational from state and inputs. Only dcache_req_o, err_o and the counters are registered.
- Counters:
  - Increment at the edge ending the qualifying cycle.
  - Saturate at all-ones; no wrap.
  - The IDLE cycles and the reset cycle are not counted.
- dcache_ack_i outside MEM_WAIT is ignored.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding enum, 2 bits: IDLE=0, RUN=1, MEM_WAIT=2, REPLAY=3;
  - CNT_W default;
  - stage-control bundle typedef {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_bubble}.
- One sub-module: sat_counter (parameterised width, synchronous clear, increment enable, saturate).
  - Instantiated for stall_cnt_o and flush_cnt_o.
  - Also instantiated for the timeout counter (width clog2(TIMEOUT+1)).

Test Plan:
- Reset then start:
  - rst_i high 2 cycles, start_i low 5 cycles -> pc_write_o=0, id_ex_bubble_o=1, stall_cnt_o=0.
  - start_i=1 -> RUN next cycle, pc_write_o=1.
- Load-use:
  - hazard_i=1 for 1 cycle in RUN -> that cycle pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; stall_cnt_o=1 afterwards.
  - hazard_i=1 and branch_taken_i=1 together -> if_id_flush_o=0, flush_cnt_o unchanged.
- Branch:
  - branch_taken_i=1 for 3 separate cycles -> if_id_flush_o=1 each, pc_write_o=1, flush_cnt_o=3.
- Miss with ack after 4 cycles:
  - miss cycle: freeze, mem_wb_bubble_o=1.
  - dcache_req_o=1 for exactly 4 cycles.
  - REPLAY cycle unfrozen despite dcache_hit_i=0.
  - stall_cnt_o=5.
- Timeout:
  - TIMEOUT=8, no ack -> err_o=1 after the 8th MEM_WAIT cycle, stays 1.
  - Late ack -> REPLAY, err_o still 1.
  - rst_i clears err_o to 0.
- Reset mid-refill:
  - rst_i in MEM_WAIT -> dcache_req_o=0 and state IDLE at that edge; a later dcache_ack_i is ignored.
  - Counters read 0.
